// File: rtl/cw_key_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// default timing constants for a 27 MHz system clock.
package cw_key_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DB_PRESS = 3'd1,
      ST_HELD     = 3'd2,
      ST_LONG     = 3'd3,
      ST_DB_REL   = 3'd4
   } cw_key_state_t;

   localparam int CW_DB_10MS_27M = 270_000;
   localparam int CW_LONG_2S_27M = 54_000_000;

endpackage

// File: rtl/cw_sync2.sv
// Two-flop synchronizer for an asynchronous pin, with a configurable value
// loaded by the asynchronous active-high reset.
module cw_sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/cw_key_debounce.sv
// Active-low push-button debouncer producing a clean level, press/release
// pulses and, when CW_LONG_PRESS_EN is defined, a long-press pulse and reset request.
module cw_key_debounce
   import cw_key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = CW_DB_10MS_27M,
   parameter int LONG_CYCLES     = CW_LONG_2S_27M
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_Key_n,
   output logic o_Level,
   output logic o_Press,
   output logic o_Release,
   output logic o_Long,
   output logic o_Rst_Req
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   cw_key_state_t   state, state_nxt;
   logic [DB_W-1:0] db_cnt, db_nxt;
   logic            key_s;
   logic            level_nxt, press_nxt, release_nxt;

   // Inverting ahead of the synchronizer lets a reset value of 0 mean "released".
   cw_sync2 #(.RST_VAL(1'b0)) u_sync (
      .i_Clk (i_Clk),
      .i_Rst (i_Rst),
      .d     (~i_Key_n),
      .q     (key_s)
   );

`ifdef CW_LONG_PRESS_EN
   localparam int LG_W = $clog2(LONG_CYCLES);
   // HELD is entered together with o_Press, so o_Long lands LONG_CYCLES later.
   localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);

   logic [LG_W-1:0] lg_cnt, lg_nxt;
   logic            long_f, long_f_nxt;
   logic            long_nxt, rst_req_nxt;
`else
   localparam int unused_long_cycles = LONG_CYCLES;
`endif

   always_comb begin
      state_nxt   = state;
      db_nxt      = db_cnt;
      level_nxt   = o_Level;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
`ifdef CW_LONG_PRESS_EN
      lg_nxt      = lg_cnt;
      long_f_nxt  = long_f;
      long_nxt    = 1'b0;
      rst_req_nxt = o_Rst_Req;
`endif
      case (state)
         ST_IDLE: begin
            if (key_s) begin
               state_nxt = ST_DB_PRESS;
               db_nxt    = '0;
            end
         end
         ST_DB_PRESS: begin
            if (!key_s) begin
               state_nxt = ST_IDLE;
            end else if (db_cnt == DB_LAST) begin
               state_nxt = ST_HELD;
               level_nxt = 1'b1;
               press_nxt = 1'b1;
`ifdef CW_LONG_PRESS_EN
               lg_nxt    = '0;
`endif
            end else begin
               db_nxt = db_cnt + 1'b1;
            end
         end
         ST_HELD: begin
            if (!key_s) begin
               state_nxt = ST_DB_REL;
               db_nxt    = '0;
`ifdef CW_LONG_PRESS_EN
            end else if (lg_cnt == LG_LAST) begin
               state_nxt   = ST_LONG;
               long_nxt    = 1'b1;
               rst_req_nxt = 1'b1;
               long_f_nxt  = 1'b1;
            end else begin
               lg_nxt = lg_cnt + 1'b1;
`endif
            end
         end
`ifdef CW_LONG_PRESS_EN
         ST_LONG: begin
            if (!key_s) begin
               state_nxt = ST_DB_REL;
               db_nxt    = '0;
            end
         end
`endif
         ST_DB_REL: begin
            if (key_s) begin
`ifdef CW_LONG_PRESS_EN
               state_nxt = long_f ? ST_LONG : ST_HELD;
`else
               state_nxt = ST_HELD;
`endif
            end else if (db_cnt == DB_LAST) begin
               state_nxt   = ST_IDLE;
               level_nxt   = 1'b0;
               release_nxt = 1'b1;
`ifdef CW_LONG_PRESS_EN
               rst_req_nxt = 1'b0;
               long_f_nxt  = 1'b0;
`endif
            end else begin
               db_nxt = db_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state     <= ST_IDLE;
         db_cnt    <= '0;
         o_Level   <= 1'b0;
         o_Press   <= 1'b0;
         o_Release <= 1'b0;
      end else begin
         state     <= state_nxt;
         db_cnt    <= db_nxt;
         o_Level   <= level_nxt;
         o_Press   <= press_nxt;
         o_Release <= release_nxt;
      end
   end

`ifdef CW_LONG_PRESS_EN
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         lg_cnt    <= '0;
         long_f    <= 1'b0;
         o_Long    <= 1'b0;
         o_Rst_Req <= 1'b0;
      end else begin
         lg_cnt    <= lg_nxt;
         long_f    <= long_f_nxt;
         o_Long    <= long_nxt;
         o_Rst_Req <= rst_req_nxt;
      end
   end
`else
   assign o_Long    = 1'b0;
   assign o_Rst_Req = 1'b0;
`endif

endmodule
